costas_stream_ctrl: RTL and testbench
=====================================

Name: costas_stream_ctrl

Overview:
- Flow controller sequencing the input-FIFO → COSTAS_LOOP → output-FIFO path in the AD_Local_CLK domain.
- Issues input-FIFO reads and drives the loop's clock enable only when a sample is present.
- Tracks loop pipeline fill, so output-FIFO writes carry only valid demodulated samples.
- Holds a credit count of output-FIFO space, so the output FIFO never overflows.

Parameters:
- DSP_LATENCY, 4: number of loop enables between a sample entering COSTAS_LOOP and its result appearing on demodout (1..15).
- OUT_DEPTH, 16: usable output-FIFO depth; initial credit value (2..1023).
- STARTUP_CYCLES, 16: idle cycles after reset before the first read (1..255).

Ports:
- clk, in, 1: AD_Local_CLK; all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- run, in, 1: software enable. 1 = stream, 0 = pause.
- in_empty, in, 1: input-FIFO empty.
- in_rd_rst_busy, in, 1: input-FIFO read-side reset busy.
- out_full, in, 1: output-FIFO full (safety only).
- out_rd_en, in, 1: downstream pop of the output FIFO; each high cycle returns one credit.
- in_rd_en, out, 1: input-FIFO read strobe.
- dsp_en, out, 1: COSTAS_LOOP clock enable.
- out_wr_en, out, 1: output-FIFO write strobe.
- state, out, 2: 0 = RESET_WAIT, 1 = WAIT_RDY, 2 = RUN, 3 = PAUSE.
- credits, out, 11: current free output-FIFO slots.
- overflow_err, out, 1: sticky error.
- sample_cnt, out, 32: number of output writes, wraps modulo 2^32.

Behaviour:
- Reset values. While rst=1 and the cycle after:
  - in_rd_en, dsp_en, out_wr_en, overflow_err = 0.
  - state = RESET_WAIT; credits = OUT_DEPTH; sample_cnt = 0.
  - Internal startup counter = 0; fill counter = 0.
- Reset mid-operation: everything returns to the reset values above, with no partial writes. The loop and both FIFOs share the same rst.
- State machine:
  - RESET_WAIT: count STARTUP_CYCLES cycles, then go to WAIT_RDY.
  - WAIT_RDY: when in_rd_rst_busy=0, go to RUN if run=1, else PAUSE.
  - RUN: if in_rd_rst_busy=1, go to WAIT_RDY; else if run=0, go to PAUSE.
  - PAUSE: if in_rd_rst_busy=1, go to WAIT_RDY; else if run=1, go to RUN.
- Read issue: in_rd_en = (state==RUN) & !in_empty & !in_rd_rst_busy & !out_full & (credits>0 | !primed).
  - in_rd_en is combinational from registered state and the inputs.
  - primed = fill counter == DSP_LATENCY.
- Loop enable: dsp_en is in_rd_en delayed by exactly 1 cycle (registered), matching the FIFO's 1-cycle read latency.
  - The loop pipeline advances only on dsp_en; it stalls otherwise.
  - A pause never drops or duplicates an in-flight sample.
- Fill tracking:
  - The fill counter counts issued reads and saturates at DSP_LATENCY.
  - A read issued while primed is a "producing" read.
- Write generation:
  - out_wr_en = dsp_en & primed_at_issue. The flag is registered alongside dsp_en.
  - The first DSP_LATENCY samples after reset prime the loop and are never written.
- Credits:
  - Decrement by 1 on a producing read.
  - Increment by 1 on out_rd_en.
  - Both in the same cycle: no change.
  - Credits never exceed OUT_DEPTH; out_rd_en at OUT_DEPTH is ignored and sets overflow_err.
  - Credits never go below 0 by construction.
- Errors: overflow_err is set when out_wr_en=1 while out_full=1, or on a credit over-return. It clears only on rst.
- sample_cnt: increments on each out_wr_en.
- Re-entry: leaving and re-entering RUN (via PAUSE or WAIT_RDY) preserves the fill counter and credits. No re-priming.

Test Plan:
- Startup and priming, with STARTUP_CYCLES=8, DSP_LATENCY=4, input FIFO non-empty, run=1:
  - First in_rd_en at cycle 9 after rst release.
  - The first 4 dsp_en pulses have out_wr_en=0; the 5th has out_wr_en=1.
- Backpressure, with OUT_DEPTH=16 and no out_rd_en, continuous input:
  - Exactly 20 reads, of which 16 produce writes.
  - Then credits=0 and in_rd_en is held 0.
  - One out_rd_en pulse allows exactly one more read and write.
- Simultaneous pop and producing read in the same cycle: credits unchanged, e.g. 7 stays 7.
- Pause mid-stream: drop run for 10 cycles with the FIFO non-empty.
  - in_rd_en=0 from the next cycle; dsp_en pulses once more, then stops.
  - On resume, sample_cnt continues with no gap or duplicate, and there is no re-priming.
- Input starvation and rst_busy:
  - Toggling in_empty gives dsp_en exactly 1 cycle after each read.
  - Asserting in_rd_rst_busy moves state to WAIT_RDY (1) and halts reads.
- Mid-operation reset: assert rst for 1 cycle in RUN with credits=3.
  - All outputs return to reset values; credits=16, sample_cnt=0, overflow_err=0.

Source files
------------

// File: rtl/costas_stream_ctrl.sv
// costas_stream_ctrl: in-FIFO -> COSTAS_LOOP -> out-FIFO flow control (clk, rst, run, FIFO flags in; read/enable/write strobes, state, credits, error, count out)
module costas_stream_ctrl #(
  parameter int DSP_LATENCY = 4,
  parameter int OUT_DEPTH = 16,
  parameter int STARTUP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        in_empty,
  input  logic        in_rd_rst_busy,
  input  logic        out_full,
  input  logic        out_rd_en,
  output logic        in_rd_en,
  output logic        dsp_en,
  output logic        out_wr_en,
  output logic [1:0]  state,
  output logic [10:0] credits,
  output logic        overflow_err,
  output logic [31:0] sample_cnt
);
  localparam logic [1:0] RESET_WAIT = 2'd0;
  localparam logic [1:0] WAIT_RDY = 2'd1;
  localparam logic [1:0] RUN = 2'd2;
  localparam logic [1:0] PAUSE = 2'd3;
  logic [7:0] start_cnt;
  logic [3:0] fill;
  logic wr_flag, primed, producing, over, give;
  logic [1:0] state_nxt;
  assign primed = fill == 4'(DSP_LATENCY);
  assign in_rd_en = state == RUN && !in_empty && !in_rd_rst_busy && !out_full && (credits != 11'd0 || !primed);
  assign producing = in_rd_en & primed;
  assign over = out_rd_en & !producing & (credits == 11'(OUT_DEPTH));
  assign give = out_rd_en & !over;
  assign out_wr_en = dsp_en & wr_flag;
  always_comb begin
    state_nxt = state == RESET_WAIT ? (start_cnt == 8'(STARTUP_CYCLES - 1) ? WAIT_RDY : RESET_WAIT) :
                in_rd_rst_busy ? WAIT_RDY : run ? RUN : PAUSE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_WAIT;
      start_cnt <= 8'd0;
      fill <= 4'd0;
      dsp_en <= 1'b0;
      wr_flag <= 1'b0;
      credits <= 11'(OUT_DEPTH);
      overflow_err <= 1'b0;
      sample_cnt <= 32'd0;
    end else begin
      state <= state_nxt;
      start_cnt <= start_cnt + 8'(state == RESET_WAIT);
      fill <= fill + 4'(in_rd_en & !primed);
      dsp_en <= in_rd_en;
      wr_flag <= producing;
      credits <= credits + 11'(give) - 11'(producing);
      overflow_err <= overflow_err | (out_wr_en & out_full) | over;
      sample_cnt <= sample_cnt + 32'(out_wr_en);
    end
  end
endmodule

// File: tb/tb_costas_stream_ctrl.sv
// tb_costas_stream_ctrl: directed scoreboard bench for costas_stream_ctrl
module tb_costas_stream_ctrl;
  localparam int L = 4;
  localparam int D = 16;
  localparam int S = 8;
  logic clk = 1'b0, rst = 1'b1, run = 1'b1, in_empty = 1'b0, in_rd_rst_busy = 1'b0;
  logic out_full = 1'b0, out_rd_en = 1'b0;
  logic in_rd_en, dsp_en, out_wr_en, overflow_err;
  logic [1:0] state;
  logic [10:0] credits;
  logic [31:0] sample_cnt;
  int asserts = 0, fails = 0;
  int reads = 0, writes = 0, mc = D, next_id = 0, pulses = 0;
  int exp_q[$];
  logic prev_rd = 1'b0, prev_prod = 1'b0, prod;

  costas_stream_ctrl #(.DSP_LATENCY(L), .OUT_DEPTH(D), .STARTUP_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .run(run), .in_empty(in_empty), .in_rd_rst_busy(in_rd_rst_busy),
    .out_full(out_full), .out_rd_en(out_rd_en), .in_rd_en(in_rd_en), .dsp_en(dsp_en),
    .out_wr_en(out_wr_en), .state(state), .credits(credits), .overflow_err(overflow_err),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
    #1;
  endtask

  // Per-cycle reference: read->enable latency, write qualification, credit ledger and write-order scoreboard.
  always @(negedge clk) begin
    chk("dsp_en_lat", dsp_en, prev_rd);
    chk("wr_qual", out_wr_en, prev_prod);
    chk("credits", credits, mc);
    if (out_wr_en) begin
      chk("sb_order", sample_cnt, exp_q.size() != 0 ? exp_q.pop_front() : -1);
      writes++;
    end
    prod = in_rd_en && reads >= L;
    if (rst) begin
      prev_rd = 1'b0;
      prev_prod = 1'b0;
      reads = 0;
      writes = 0;
      mc = D;
      next_id = 0;
      exp_q.delete();
    end else begin
      prev_rd = in_rd_en;
      prev_prod = prod;
      if (in_rd_en) reads++;
      if (prod) exp_q.push_back(next_id++);
      mc = (prod && !out_rd_en) ? mc - 1 : (out_rd_en && !prod && mc < D) ? mc + 1 : mc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drv;
    drv;
    smp;
    chk("rst_state", state, 0);
    chk("rst_credits", credits, D);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_rd", in_rd_en, 0);
    chk("rst_dsp", dsp_en, 0);
    chk("rst_wr", out_wr_en, 0);
    chk("rst_ovf", overflow_err, 0);
    drv;
    rst = 1'b0;
    drv;
    smp;
    chk("post_rst_state", state, 0);
    chk("post_rst_credits", credits, D);
    repeat (S - 1) drv;
    smp;
    chk("startup_rd_low", in_rd_en, 0);
    chk("startup_wait_rdy", state, 1);
    drv;
    smp;
    chk("first_rd", in_rd_en, 1);
    chk("first_run", state, 2);
    for (int i = 0; i < 50; i++) begin
      smp;
      if (out_wr_en) break;
      if (dsp_en) pulses++;
    end
    chk("prime_pulses", pulses, L);
    repeat (40) smp;
    chk("bp_reads", reads, L + D);
    chk("bp_writes", writes, D);
    chk("bp_credits", credits, 0);
    chk("bp_rd_held", in_rd_en, 0);
    chk("bp_cnt", sample_cnt, D);
    drv;
    out_rd_en = 1'b1;
    drv;
    out_rd_en = 1'b0;
    repeat (5) smp;
    chk("pop_reads", reads, L + D + 1);
    chk("pop_writes", writes, D + 1);
    chk("pop_credits", credits, 0);
    drv;
    in_empty = 1'b1;
    out_rd_en = 1'b1;
    repeat (7) drv;
    out_rd_en = 1'b0;
    smp;
    chk("refill_credits", credits, 7);
    drv;
    in_empty = 1'b0;
    out_rd_en = 1'b1;
    smp;
    chk("sim_rd", in_rd_en, 1);
    drv;
    in_empty = 1'b1;
    out_rd_en = 1'b0;
    smp;
    chk("sim_credits", credits, 7);
    drv;
    in_empty = 1'b0;
    repeat (2) drv;
    run = 1'b0;
    drv;
    smp;
    chk("pause_state", state, 3);
    chk("pause_rd", in_rd_en, 0);
    chk("pause_dsp_last", dsp_en, 1);
    smp;
    chk("pause_dsp_stop", dsp_en, 0);
    repeat (8) drv;
    run = 1'b1;
    repeat (12) smp;
    chk("resume_reads", reads, 29);
    chk("resume_cnt", sample_cnt, 25);
    chk("resume_credits", credits, 0);
    for (int i = 0; i < 6; i++) begin
      drv;
      in_empty = 1'b0;
      out_rd_en = 1'b1;
      drv;
      in_empty = 1'b1;
      out_rd_en = 1'b0;
    end
    smp;
    chk("starve_reads", reads, 34);
    chk("starve_credits", credits, 1);
    drv;
    in_empty = 1'b0;
    in_rd_rst_busy = 1'b1;
    smp;
    chk("busy_rd", in_rd_en, 0);
    smp;
    chk("busy_state", state, 1);
    chk("busy_rd_held", in_rd_en, 0);
    drv;
    in_rd_rst_busy = 1'b0;
    smp;
    chk("busy_rel_state", state, 1);
    drv;
    smp;
    chk("busy_run", state, 2);
    chk("busy_run_rd", in_rd_en, 1);
    drv;
    in_empty = 1'b1;
    out_rd_en = 1'b1;
    repeat (3) drv;
    out_rd_en = 1'b0;
    smp;
    chk("mid_credits", credits, 3);
    chk("mid_cnt", sample_cnt, 31);
    drv;
    in_empty = 1'b0;
    rst = 1'b1;
    drv;
    rst = 1'b0;
    smp;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_credits", credits, D);
    chk("mid_rst_cnt", sample_cnt, 0);
    chk("mid_rst_ovf", overflow_err, 0);
    chk("mid_rst_rd", in_rd_en, 0);
    chk("mid_rst_dsp", dsp_en, 0);
    chk("mid_rst_wr", out_wr_en, 0);
    drv;
    out_rd_en = 1'b1;
    drv;
    out_rd_en = 1'b0;
    smp;
    chk("ovf_set", overflow_err, 1);
    chk("ovf_credits", credits, D);
    drv;
    smp;
    chk("ovf_sticky", overflow_err, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
